// File: rtl/cdb_pkg.sv
// Shared constants for the common-data-bus arbiter and its helpers.
package cdb_pkg;

    localparam int N_REQ  = 8;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 6;
    localparam int SEL_W  = 3;

    // Functional-unit slot assignment on the CDB request vector.
    localparam logic [SEL_W-1:0] FU_ALU = 3'd0;
    localparam logic [SEL_W-1:0] FU_SHF = 3'd1;
    localparam logic [SEL_W-1:0] FU_MUL = 3'd2;
    localparam logic [SEL_W-1:0] FU_DIV = 3'd3;
    localparam logic [SEL_W-1:0] FU_LSU = 3'd4;
    localparam logic [SEL_W-1:0] FU_CP0 = 3'd5;
    localparam logic [SEL_W-1:0] FU_HLO = 3'd6;
    localparam logic [SEL_W-1:0] FU_BRU = 3'd7;

    // Wrap-around increment of a requester index.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        next_idx = idx + 3'd1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin pick: rotate the eligible vector so ptr sits at bit 0,
// find the first set bit, then rotate the result back to absolute index.
module rr_pick
    import cdb_pkg::*;
(
    input  logic [N_REQ-1:0] i_elig,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    logic [N_REQ-1:0] rot_s;
    logic [SEL_W-1:0] off_s;
    logic             found_s;

    // Rotate so that bit k of rot_s is requester (ptr + k) mod 8.
    always_comb begin
        rot_s = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            rot_s[k] = i_elig[i_ptr + 3'(k)];
        end
    end

    // Find-first from the lowest rotated position; scanning downward
    // leaves the lowest set bit as the final assignment.
    always_comb begin
        off_s   = 3'd0;
        found_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s   = 3'(k);
                found_s = 1'b1;
            end else begin
                off_s   = off_s;
                found_s = found_s;
            end
        end
    end

    // Rotate back; with nothing eligible the index rests on ptr.
    always_comb begin
        o_idx = i_ptr + off_s;
        o_any = found_s;
        if (found_s) begin
            o_gnt = 8'h01 << o_idx;
        end else begin
            o_gnt = 8'h00;
        end
    end

endmodule

// File: rtl/mux_8_32.sv
// Plain 8:1 multiplexer of 32-bit words; word i lives at [i*32 +: 32].
module mux_8_32 (
    input  logic [255:0] i_data,
    input  logic [2:0]   i_sel,
    output logic [31:0]  o_data
);

    // Select one 32-bit word from the packed input vector.
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_sel)
            3'd0:    o_data = i_data[31:0];
            3'd1:    o_data = i_data[63:32];
            3'd2:    o_data = i_data[95:64];
            3'd3:    o_data = i_data[127:96];
            3'd4:    o_data = i_data[159:128];
            3'd5:    o_data = i_data[191:160];
            3'd6:    o_data = i_data[223:192];
            3'd7:    o_data = i_data[255:224];
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin grant among eight functional units, then one
// registered broadcast of the winner's result and tag per cycle.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    input  logic [N_REQ*TAG_W-1:0] i_tag,
    input  logic [N_REQ-1:0]       i_mask,
    input  logic                   i_stall,
    input  logic                   i_flush,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [SEL_W-1:0]       o_sel,
    output logic                   o_cdb_valid,
    output logic [DATA_W-1:0]      o_cdb_data,
    output logic [TAG_W-1:0]       o_cdb_tag
);

    logic [SEL_W-1:0]  ptr_q,   ptr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [TAG_W-1:0]  tag_q,   tag_d;

    logic [N_REQ-1:0]  elig_s;
    logic [N_REQ-1:0]  pick_gnt_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic              pick_any_s;
    logic              fire_s;
    logic [DATA_W-1:0] mux_data_s;
    logic [TAG_W-1:0]  mux_tag_s;

    assign elig_s = i_req & i_mask;

    rr_pick u_pick (
        .i_elig (elig_s),
        .i_ptr  (ptr_q),
        .o_gnt  (pick_gnt_s),
        .o_idx  (pick_idx_s),
        .o_any  (pick_any_s)
    );

    mux_8_32 u_data_mux (
        .i_data (i_data),
        .i_sel  (o_sel),
        .o_data (mux_data_s)
    );

    // Grant gating: nothing is granted while consumers stall or a flush is active.
    always_comb begin
        o_sel = pick_idx_s;
        if (i_stall || i_flush) begin
            o_gnt  = 8'h00;
            fire_s = 1'b0;
        end else begin
            o_gnt  = pick_gnt_s;
            fire_s = pick_any_s;
        end
    end

    // Tag select for the winning unit.
    always_comb begin
        mux_tag_s = 6'h00;
        case (o_sel)
            3'd0:    mux_tag_s = i_tag[0*TAG_W +: TAG_W];
            3'd1:    mux_tag_s = i_tag[1*TAG_W +: TAG_W];
            3'd2:    mux_tag_s = i_tag[2*TAG_W +: TAG_W];
            3'd3:    mux_tag_s = i_tag[3*TAG_W +: TAG_W];
            3'd4:    mux_tag_s = i_tag[4*TAG_W +: TAG_W];
            3'd5:    mux_tag_s = i_tag[5*TAG_W +: TAG_W];
            3'd6:    mux_tag_s = i_tag[6*TAG_W +: TAG_W];
            3'd7:    mux_tag_s = i_tag[7*TAG_W +: TAG_W];
            default: mux_tag_s = 6'h00;
        endcase
    end

    // Next state: flush drops the broadcast, stall freezes everything,
    // a grant launches a broadcast and moves ptr past the winner.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_stall) begin
            valid_d = valid_q;
        end else if (fire_s) begin
            ptr_d   = next_idx(pick_idx_s);
            valid_d = 1'b1;
            data_d  = mux_data_s;
            tag_d   = mux_tag_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and broadcast registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= 3'd0;
            valid_q <= 1'b0;
            data_q  <= 32'h0000_0000;
            tag_q   <= 6'h00;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign o_cdb_valid = valid_q;
    assign o_cdb_data  = data_q;
    assign o_cdb_tag   = tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

    logic         clk;
    logic         rst_n;
    logic [7:0]   i_req;
    logic [255:0] i_data;
    logic [47:0]  i_tag;
    logic [7:0]   i_mask;
    logic         i_stall;
    logic         i_flush;
    logic [7:0]   o_gnt;
    logic [2:0]   o_sel;
    logic         o_cdb_valid;
    logic [31:0]  o_cdb_data;
    logic [5:0]   o_cdb_tag;

    int checks = 0;
    int errors = 0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (i_req),
        .i_data      (i_data),
        .i_tag       (i_tag),
        .i_mask      (i_mask),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .o_gnt       (o_gnt),
        .o_sel       (o_sel),
        .o_cdb_valid (o_cdb_valid),
        .o_cdb_data  (o_cdb_data),
        .o_cdb_tag   (o_cdb_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let outputs settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_req   = 8'h00;
        i_mask  = 8'hFF;
        i_stall = 1'b0;
        i_flush = 1'b0;
        for (int i = 0; i < 8; i++) begin
            i_data[i*32 +: 32] = 32'h1000_0000 + 32'(i);
            i_tag[i*6 +: 6]    = (i == 2) ? 6'h2A : 6'(6'h10 + 6'(i));
        end
        tick();
        tick();
        chk("rst_valid", 32'(o_cdb_valid), 32'd0);
        chk("rst_data", o_cdb_data, 32'h0000_0000);
        chk("rst_tag", 32'(o_cdb_tag), 32'd0);
        chk("rst_sel", 32'(o_sel), 32'd0);

        // Idle: nothing requested, nothing broadcast, sel rests on ptr 0.
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("idle_valid", 32'(o_cdb_valid), 32'd0);
            chk("idle_sel", 32'(o_sel), 32'd0);
            chk("idle_gnt", 32'(o_gnt), 32'd0);
        end

        // All requesting: grants rotate 0..7 then 0, data follows one cycle later.
        i_req = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            #1;
            chk("rr_gnt", 32'(o_gnt), 32'(8'h01 << (c % 8)));
            chk("rr_sel", 32'(o_sel), 32'(c % 8));
            tick();
            chk("rr_valid", 32'(o_cdb_valid), 32'd1);
            chk("rr_data", o_cdb_data, 32'h1000_0000 + 32'(c % 8));
            chk("rr_tag", 32'(o_cdb_tag), (c % 8 == 2) ? 32'h2A : 32'h10 + 32'(c % 8));
        end
        // ptr is now 1; grant unit 4 alone to move ptr to 5.
        i_req = 8'h10;
        #1;
        chk("p5_gnt", 32'(o_gnt), 32'h10);
        tick();

        // ptr=5 with units 0 and 3: unit 0 wins, then ptr=1 makes unit 3 win.
        i_req = 8'b0000_1001;
        #1;
        chk("wrap_gnt0", 32'(o_gnt), 32'h01);
        chk("wrap_sel0", 32'(o_sel), 32'd0);
        tick();
        chk("wrap_data0", o_cdb_data, 32'h1000_0000);
        #1;
        chk("wrap_gnt3", 32'(o_gnt), 32'h08);
        chk("wrap_sel3", 32'(o_sel), 32'd3);
        tick();
        chk("wrap_data3", o_cdb_data, 32'h1000_0003);

        // Broadcast tag 2A from unit 2 (ptr 4 -> 3), then stall three cycles.
        i_req = 8'h04;
        tick();
        chk("st_tag0", 32'(o_cdb_tag), 32'h2A);
        i_req   = 8'h01;
        i_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_gnt", 32'(o_gnt), 32'd0);
            tick();
            chk("st_valid", 32'(o_cdb_valid), 32'd1);
            chk("st_tag", 32'(o_cdb_tag), 32'h2A);
            chk("st_data", o_cdb_data, 32'h1000_0002);
        end
        i_stall = 1'b0;
        #1;
        chk("st_rel_gnt", 32'(o_gnt), 32'h01);
        tick();
        chk("st_rel_tag", 32'(o_cdb_tag), 32'h10);
        chk("st_rel_valid", 32'(o_cdb_valid), 32'd1);

        // Flush with stall while valid: broadcast dropped, ptr (1) unchanged.
        i_req   = 8'h02;
        i_stall = 1'b1;
        i_flush = 1'b1;
        #1;
        chk("fl_gnt", 32'(o_gnt), 32'd0);
        tick();
        chk("fl_valid", 32'(o_cdb_valid), 32'd0);
        i_stall = 1'b0;
        i_flush = 1'b0;
        i_req   = 8'h81;
        #1;
        chk("fl_ptr_gnt", 32'(o_gnt), 32'h80);
        chk("fl_ptr_sel", 32'(o_sel), 32'd7);
        tick();
        chk("fl_after_data", o_cdb_data, 32'h1000_0007);

        // Masked requester (ptr now 0) is never granted until unmasked.
        i_mask = 8'b1111_1011;
        i_req  = 8'h04;
        #1;
        chk("mk_gnt", 32'(o_gnt), 32'd0);
        chk("mk_sel", 32'(o_sel), 32'd0);
        tick();
        chk("mk_valid", 32'(o_cdb_valid), 32'd0);
        i_mask = 8'hFF;
        #1;
        chk("um_gnt", 32'(o_gnt), 32'h04);
        chk("um_sel", 32'(o_sel), 32'd2);
        tick();
        chk("um_valid", 32'(o_cdb_valid), 32'd1);
        chk("um_tag", 32'(o_cdb_tag), 32'h2A);

        // Reset mid-broadcast clears valid and returns ptr to 0.
        i_req = 8'h06;
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", 32'(o_cdb_valid), 32'd0);
        chk("mrst_data", o_cdb_data, 32'h0000_0000);
        chk("mrst_sel", 32'(o_sel), 32'd1);
        rst_n = 1'b1;
        i_req = 8'h00;
        tick();
        chk("mrst_noreplay", 32'(o_cdb_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
